// File: rtl/bp_ckpt_queue_pkg.sv
// Shared branch-predictor types: GHSR width and the checkpoint entry saved per in-flight branch.
package bp_ckpt_queue_pkg;

  localparam int unsigned GSHARE_GHSR_WIDTH = 8;

  typedef struct packed {
    logic [31:0]                  pc;
    logic [GSHARE_GHSR_WIDTH-1:0] ghsr;
    logic                         pred;
  } ckpt_entry_t;

endpackage

// File: rtl/bp_ckpt_queue.sv
// In-order checkpoint queue for predicted branches: two pushes per cycle from fetch,
// one resolve per cycle from EXE, producing predictor updates and mispredict flushes.
module bp_ckpt_queue
  import bp_ckpt_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GW    = GSHARE_GHSR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push0_valid,
  input  logic [31:0]              push0_pc,
  input  logic [GW-1:0]            push0_ghsr,
  input  logic                     push0_pred,
  input  logic                     push1_valid,
  input  logic [31:0]              push1_pc,
  input  logic [GW-1:0]            push1_ghsr,
  input  logic                     push1_pred,
  output logic                     push_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     kill,
  output logic                     upd_valid,
  output logic [31:0]              upd_pc,
  output logic [GW-1:0]            upd_ghsr,
  output logic                     upd_taken,
  output logic                     flush_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow_err
);

  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned HW     = GSHARE_GHSR_WIDTH;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("bp_ckpt_queue: DEPTH must be a power of 2 and at least 4");
  end
  if (GW > HW) begin : g_bad_gw
    $error("bp_ckpt_queue: GW exceeds the checkpoint entry GHSR field");
  end

  ckpt_entry_t       mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  ckpt_entry_t       head;
  ckpt_entry_t       ent0;
  ckpt_entry_t       ent1;
  logic              do_resolve;
  logic              mispredict;
  logic              clear;
  logic              wr_en0;
  logic              wr_en1;
  logic [CW-1:0]     n_push;

  // Next-state decode for push, resolve and clear
  always_comb begin
    push_ready = (count <= CW'(DEPTH - 2));
    head       = mem[rd_ptr];
    ent0       = '{pc: push0_pc, ghsr: HW'(push0_ghsr), pred: push0_pred};
    ent1       = '{pc: push1_pc, ghsr: HW'(push1_ghsr), pred: push1_pred};
    do_resolve = resolve_valid && (count != '0);
    mispredict = do_resolve && (resolve_taken ^ head.pred);
    clear      = kill || mispredict;
    wr_en0     = push_ready && !clear && push0_valid;
    wr_en1     = push_ready && !clear && push1_valid;
    n_push     = CW'(wr_en0) + CW'(wr_en1);
  end

  // Pointers, occupancy and status strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      upd_valid     <= 1'b0;
      flush_valid   <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      upd_valid   <= do_resolve;
      flush_valid <= mispredict && !kill;
      if (resolve_valid && (count == '0)) begin
        underflow_err <= 1'b1;
      end
      if (clear) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(n_push);
        rd_ptr <= rd_ptr + PW'(do_resolve);
        count  <= count + n_push - CW'(do_resolve);
      end
    end
  end

  // Entry storage; slot1 lands behind slot0 when both push
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_en0) begin
        mem[wr_ptr] <= ent0;
      end
      if (wr_en1) begin
        mem[wr_ptr + PW'(wr_en0)] <= ent1;
      end
    end
  end

  // Update payload holds between resolves
  always_ff @(posedge clk) begin
    if (!reset && do_resolve) begin
      upd_pc    <= head.pc;
      upd_ghsr  <= GW'(head.ghsr);
      upd_taken <= resolve_taken;
    end
  end

endmodule

// File: tb/tb_bp_ckpt_queue.sv
// Directed self-checking bench for bp_ckpt_queue (DEPTH=8, GW=8).
module tb_bp_ckpt_queue;

  logic        clk;
  logic        reset;
  logic        push0_valid, push1_valid;
  logic [31:0] push0_pc, push1_pc;
  logic [7:0]  push0_ghsr, push1_ghsr;
  logic        push0_pred, push1_pred;
  logic        push_ready;
  logic        resolve_valid, resolve_taken, kill;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [7:0]  upd_ghsr;
  logic        upd_taken;
  logic        flush_valid;
  logic [3:0]  count;
  logic        underflow_err;

  int errors = 0;
  int checks = 0;

  bp_ckpt_queue #(.DEPTH(8), .GW(8)) dut (
    .clk(clk), .reset(reset),
    .push0_valid(push0_valid), .push0_pc(push0_pc), .push0_ghsr(push0_ghsr), .push0_pred(push0_pred),
    .push1_valid(push1_valid), .push1_pc(push1_pc), .push1_ghsr(push1_ghsr), .push1_pred(push1_pred),
    .push_ready(push_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .kill(kill),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghsr(upd_ghsr), .upd_taken(upd_taken),
    .flush_valid(flush_valid), .count(count), .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    push0_valid = 0; push1_valid = 0; resolve_valid = 0; resolve_taken = 0;
    kill = 0; reset = 0;
    push0_pc = '0; push0_ghsr = '0; push0_pred = 0;
    push1_pc = '0; push1_ghsr = '0; push1_pred = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic set_push0(input logic [31:0] pc, input logic [7:0] g, input logic p);
    push0_valid = 1; push0_pc = pc; push0_ghsr = g; push0_pred = p;
  endtask

  task automatic set_push1(input logic [31:0] pc, input logic [7:0] g, input logic p);
    push1_valid = 1; push1_pc = pc; push1_ghsr = g; push1_pred = p;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid got=%b exp=0", upd_valid); end
    checks++; if (flush_valid !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush_valid); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", underflow_err); end
  endtask

  task automatic test_basic();
    do_reset();
    set_push0(32'h100, 8'h05, 1'b1);
    tick(); idle();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL basic_count1 got=%0d exp=1", count); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL basic_no_upd got=%b exp=0", upd_valid); end
    resolve_valid = 1; resolve_taken = 1;
    tick(); idle();
    checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL basic_upd_valid got=%b exp=1", upd_valid); end
    checks++; if (upd_pc !== 32'h100) begin errors++; $display("FAIL basic_upd_pc got=%h exp=00000100", upd_pc); end
    checks++; if (upd_ghsr !== 8'h05) begin errors++; $display("FAIL basic_upd_ghsr got=%h exp=05", upd_ghsr); end
    checks++; if (upd_taken !== 1'b1) begin errors++; $display("FAIL basic_upd_taken got=%b exp=1", upd_taken); end
    checks++; if (flush_valid !== 1'b0) begin errors++; $display("FAIL basic_flush got=%b exp=0", flush_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_count0 got=%0d exp=0", count); end
    tick();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL hold_upd_valid got=%b exp=0", upd_valid); end
    checks++; if (upd_pc !== 32'h100) begin errors++; $display("FAIL hold_upd_pc got=%h exp=00000100", upd_pc); end
    checks++; if (upd_ghsr !== 8'h05) begin errors++; $display("FAIL hold_upd_ghsr got=%h exp=05", upd_ghsr); end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_push0(32'h200, 8'h11, 1'b0);
    set_push1(32'h204, 8'h22, 1'b1);
    tick(); idle();
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL mp_count2 got=%0d exp=2", count); end
    resolve_valid = 1; resolve_taken = 1;
    set_push0(32'h208, 8'h33, 1'b0);
    tick(); idle();
    checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL mp_upd_valid got=%b exp=1", upd_valid); end
    checks++; if (upd_pc !== 32'h200) begin errors++; $display("FAIL mp_upd_pc got=%h exp=00000200", upd_pc); end
    checks++; if (upd_taken !== 1'b1) begin errors++; $display("FAIL mp_upd_taken got=%b exp=1", upd_taken); end
    checks++; if (flush_valid !== 1'b1) begin errors++; $display("FAIL mp_flush got=%b exp=1", flush_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mp_count0 got=%0d exp=0", count); end
    tick();
    checks++; if (flush_valid !== 1'b0) begin errors++; $display("FAIL mp_flush_pulse got=%b exp=0", flush_valid); end
    resolve_valid = 1; resolve_taken = 0;
    tick(); idle();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL uf_upd_valid got=%b exp=0", upd_valid); end
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_err got=%b exp=1", underflow_err); end
    tick();
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%b exp=1", underflow_err); end
  endtask

  task automatic test_full();
    logic [31:0] exp_pc [8];
    exp_pc = '{32'h304, 32'h310, 32'h314, 32'h320, 32'h324, 32'h330, 32'h340, 32'h344};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_push0(32'h300 + 32'(16 * k), 8'(k), 1'b0);
      set_push1(32'h304 + 32'(16 * k), 8'(k), 1'b0);
      tick(); idle();
    end
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL full_count6 got=%0d exp=6", count); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL full_ready6 got=%b exp=1", push_ready); end
    set_push0(32'h330, 8'h30, 1'b0);
    tick(); idle();
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_count7 got=%0d exp=7", count); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_ready7 got=%b exp=0", push_ready); end
    set_push0(32'hdead, 8'hee, 1'b1);
    set_push1(32'hbeef, 8'hee, 1'b1);
    tick(); idle();
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_drop7 got=%0d exp=7", count); end
    resolve_valid = 1; resolve_taken = 0;
    tick(); idle();
    checks++; if (upd_pc !== 32'h300) begin errors++; $display("FAIL full_first_pc got=%h exp=00000300", upd_pc); end
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL full_pop6 got=%0d exp=6", count); end
    set_push0(32'h340, 8'h40, 1'b0);
    set_push1(32'h344, 8'h44, 1'b0);
    tick(); idle();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count8 got=%0d exp=8", count); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_ready8 got=%b exp=0", push_ready); end
    set_push0(32'hdead, 8'hee, 1'b1);
    tick(); idle();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_drop8 got=%0d exp=8", count); end
    for (int i = 0; i < 8; i++) begin
      resolve_valid = 1; resolve_taken = 0;
      tick(); idle();
      checks++; if (upd_pc !== exp_pc[i]) begin errors++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, upd_pc, exp_pc[i]); end
      checks++; if (count !== 4'(7 - i)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 7 - i); end
    end
    checks++; if (flush_valid !== 1'b0) begin errors++; $display("FAIL drain_flush got=%b exp=0", flush_valid); end
  endtask

  task automatic test_wrap();
    logic p;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      p = 1'(i % 2);
      set_push0(32'h1000 + 32'(4 * i), 8'(i), p);
      tick(); idle();
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL wrap_count1[%0d] got=%0d exp=1", i, count); end
      resolve_valid = 1; resolve_taken = p;
      tick(); idle();
      checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL wrap_upd_valid[%0d] got=%b exp=1", i, upd_valid); end
      checks++; if (upd_pc !== 32'h1000 + 32'(4 * i)) begin errors++; $display("FAIL wrap_upd_pc[%0d] got=%h exp=%h", i, upd_pc, 32'h1000 + 32'(4 * i)); end
      checks++; if (flush_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL wrap_state[%0d] got=flush%b/cnt%0d exp=flush0/cnt0", i, flush_valid, count); end
    end
  endtask

  task automatic test_kill();
    do_reset();
    set_push0(32'h500, 8'h50, 1'b1);
    set_push1(32'h504, 8'h51, 1'b1);
    tick(); idle();
    set_push0(32'h508, 8'h52, 1'b1);
    tick(); idle();
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL kill_count3 got=%0d exp=3", count); end
    kill = 1; resolve_valid = 1; resolve_taken = 1;
    set_push0(32'h50c, 8'h53, 1'b0);
    tick(); idle();
    checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL kill_upd_valid got=%b exp=1", upd_valid); end
    checks++; if (upd_pc !== 32'h500) begin errors++; $display("FAIL kill_upd_pc got=%h exp=00000500", upd_pc); end
    checks++; if (flush_valid !== 1'b0) begin errors++; $display("FAIL kill_flush got=%b exp=0", flush_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL kill_count0 got=%0d exp=0", count); end
    set_push0(32'h600, 8'h60, 1'b0);
    tick(); idle();
    resolve_valid = 1; resolve_taken = 0;
    tick(); idle();
    checks++; if (upd_pc !== 32'h600 || upd_ghsr !== 8'h60) begin errors++; $display("FAIL kill_after got=%h/%h exp=00000600/60", upd_pc, upd_ghsr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_push0(32'h700, 8'h70, 1'b0); set_push1(32'h704, 8'h71, 1'b0);
    tick(); idle();
    set_push0(32'h708, 8'h72, 1'b0); set_push1(32'h70c, 8'h73, 1'b0);
    tick(); idle();
    set_push0(32'h710, 8'h74, 1'b0);
    tick(); idle();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL rmid_count5 got=%0d exp=5", count); end
    reset = 1; resolve_valid = 1; resolve_taken = 1; kill = 1;
    set_push0(32'h714, 8'h75, 1'b0);
    tick(); idle();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL rmid_upd_valid got=%b exp=0", upd_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rmid_count0 got=%0d exp=0", count); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", push_ready); end
    checks++; if (flush_valid !== 1'b0) begin errors++; $display("FAIL rmid_flush got=%b exp=0", flush_valid); end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_basic();
    test_mispredict();
    test_full();
    test_wrap();
    test_kill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
